// File: rtl/mem_copy_engine.sv
// Word-at-a-time memory copy engine: alternates READ/WRITE over a shared address port.
// Optional running checksum of copied words is enabled with MEM_COPY_CHECKSUM_EN.
module mem_copy_engine #(
    parameter int WIDTH    = 8,
    parameter int ADD_SIZE = 24,
    parameter int LEN_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADD_SIZE-1:0]   src_addr,
    input  logic [ADD_SIZE-1:0]   dst_addr,
    input  logic [LEN_W-1:0]      len_words,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADD_SIZE-1:0]   mem_addr,
    output logic [4*WIDTH-1:0]    mem_data,
    input  logic [4*WIDTH-1:0]    mem_q,
    output logic [31:0]           checksum
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q;
    logic [ADD_SIZE-1:0]   src_q, dst_q;
    logic [ADD_SIZE-1:0]   src_d, dst_d;
    logic [LEN_W-1:0]      cnt_q;
    logic [4*WIDTH-1:0]    buf_q;
    logic                  done_q;
    logic                  mem_en_q;
    logic [ADD_SIZE-1:0]   mem_addr_q;

    // Pointer increments wrap modulo 2**ADD_SIZE through the fixed width.
    assign src_d = src_q + ADD_SIZE'(4);
    assign dst_d = dst_q + ADD_SIZE'(4);

`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] sum_q;
    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            done_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q     <= 1'b0;
                    mem_en_q   <= 1'b0;
                    mem_addr_q <= '0;
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        cnt_q <= len_words;
`ifdef MEM_COPY_CHECKSUM_EN
                        sum_q <= '0;
`endif
                        if (len_words == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= READ;
                            mem_addr_q <= src_addr;
                        end
                    end
                end
                READ: begin
                    buf_q      <= mem_q;
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= dst_q;
                    state_q    <= WRITE;
                end
                WRITE: begin
                    src_q    <= src_d;
                    dst_q    <= dst_d;
                    cnt_q    <= cnt_q - LEN_W'(1);
                    mem_en_q <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
                    sum_q    <= sum_q + 32'(buf_q);
`endif
                    if (cnt_q == LEN_W'(1)) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        mem_addr_q <= '0;
                    end else begin
                        state_q    <= READ;
                        mem_addr_q <= src_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    mem_en_q   <= 1'b0;
                    mem_addr_q <= '0;
                end
            endcase
        end
    end

    assign busy     = (state_q == READ) || (state_q == WRITE);
    assign done     = done_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = (state_q == WRITE) ? buf_q : '0;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: byte memory model plus a word-by-word forward-copy reference.
// Memory is 4 KiB aliased on the low 12 address bits; reference uses the same aliasing.
module tb_mem_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] src_addr;
    logic [23:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic [23:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_q;
    logic [31:0] checksum;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        ld_en;
    logic [23:0] ld_a;
    logic [31:0] ld_w;
    logic [31:0] ref_sum;

    mem_copy_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_q(mem_q), .checksum(checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_dut(input logic [23:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[12'(a + 24'(k))];
        return w;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [23:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[12'(a + 24'(k))];
        return w;
    endfunction

    function automatic logic [31:0] cs_exp(input logic [31:0] s);
`ifdef MEM_COPY_CHECKSUM_EN
        return s;
`else
        return 32'h0 & s;
`endif
    endfunction

    // Memory model: write commits on negedge, asynchronous read presented for mem_addr.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem_q = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_en)
                for (int k = 0; k < 4; k++) mem[12'(mem_addr + 24'(k))] = mem_data[8*k +: 8];
            if (ld_en)
                for (int k = 0; k < 4; k++) mem[12'(ld_a + 24'(k))] = ld_w[8*k +: 8];
            mem_q = rd_dut(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_ref(input logic [23:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) ref_mem[12'(a + 24'(k))] = w[8*k +: 8];
    endtask

    task automatic load_word(input logic [23:0] a, input logic [31:0] w);
        wr_ref(a, w);
        ld_a  = a;
        ld_w  = w;
        ld_en = 1'b1;
        @(negedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic compare_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check(tag, 64'(diffs), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_en"},   64'(mem_en), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_data"}, 64'(mem_data), 64'd0);
    endtask

    // One copy from edge 0 onward; abort>0 asserts rst during that cycle.
    task automatic run_copy(input logic [23:0] src, input logic [23:0] dst, input int len,
                            input bit hold, input int abort);
        int          total;
        logic [23:0] exp_addr;
        logic [31:0] exp_data;
        logic [31:0] w;
        total     = (len == 0) ? 1 : 2 * len + 1;
        src_addr  = src;
        dst_addr  = dst;
        len_words = 16'(len);
        start     = 1'b1;
        ref_sum   = 32'h0;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= total; c++) begin
            exp_data = 32'h0;
            exp_addr = 24'h0;
            if (c <= 2 * len) begin
                if (c % 2 == 1) begin
                    exp_addr = src + 24'(4 * ((c - 1) / 2));
                end else begin
                    exp_addr = dst + 24'(4 * (c / 2 - 1));
                    w        = rd_ref(src + 24'(4 * (c / 2 - 1)));
                    exp_data = w;
                    wr_ref(exp_addr, w);
                    ref_sum  = ref_sum + w;
                end
            end
            check($sformatf("c%0d_busy", c), 64'(busy), 64'(c <= 2 * len));
            check($sformatf("c%0d_en", c), 64'(mem_en), 64'((c % 2 == 0) && (c <= 2 * len)));
            check($sformatf("c%0d_addr", c), 64'(mem_addr), 64'(exp_addr));
            check($sformatf("c%0d_data", c), 64'(mem_data), 64'(exp_data));
            check($sformatf("c%0d_done", c), 64'(done), 64'(c == total));
            if (c == abort) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                check_idle("after_rst");
                check("after_rst_cs", 64'(checksum), 64'd0);
                return;
            end
            if (c == total) check("done_cs", 64'(checksum), 64'(cs_exp(ref_sum)));
            @(posedge clk);
            #1;
        end
        check_idle("post_done");
        check("post_done_cs", 64'(checksum), 64'(cs_exp(ref_sum)));
    endtask

    initial begin
        logic [23:0] rs, rd;
        int          rl;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        ld_en = 1'b0; ld_a = '0; ld_w = '0;
        start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_cs", 64'(checksum), 64'd0);
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic three-word copy.
        load_word(24'h10, 32'h11111111);
        load_word(24'h14, 32'h22222222);
        load_word(24'h18, 32'h33333333);
        run_copy(24'h10, 24'h100, 3, 1'b0, 0);
        check("basic_cs_value", 64'(checksum), 64'(cs_exp(32'h66666666)));
        check("basic_dst_word2", 64'(rd_dut(24'h108)), 64'h33333333);
        compare_mem("basic_mem");

        // Zero-length copy.
        run_copy(24'h20, 24'h200, 0, 1'b0, 0);
        compare_mem("len0_mem");

        // Source pointer wraps past the top of the address space.
        load_word(24'hFFFFFC, 32'hCAFEF00D);
        load_word(24'h000000, 32'h0BADBEEF);
        run_copy(24'hFFFFFC, 24'h000040, 2, 1'b0, 0);
        compare_mem("wrap_mem");

        // Overlapping forward copy replicates the first word.
        load_word(24'h0, 32'hAABBCCDD);
        run_copy(24'h0, 24'h4, 3, 1'b0, 0);
        check("ovl_w4", 64'(rd_dut(24'h4)), 64'hAABBCCDD);
        check("ovl_w12", 64'(rd_dut(24'hC)), 64'hAABBCCDD);
        compare_mem("ovl_mem");

        // Reset in cycle 3 of a four-word copy, then a normal rerun.
        for (int i = 0; i < 4; i++) load_word(24'h400 + 24'(4 * i), $urandom);
        run_copy(24'h400, 24'h500, 4, 1'b0, 3);
        compare_mem("abort_mem");
        run_copy(24'h400, 24'h500, 4, 1'b0, 0);
        compare_mem("rerun_mem");

        // Start held high: second copy accepted only from the IDLE cycle after done.
        load_word(24'h600, 32'h01234567);
        load_word(24'h604, 32'h89ABCDEF);
        run_copy(24'h600, 24'h700, 2, 1'b1, 0);
        run_copy(24'h600, 24'h700, 2, 1'b0, 0);
        compare_mem("hold_mem");

        // Randomized copies, including unaligned and overlapping regions.
        for (int t = 0; t < 6; t++) begin
            rs = 24'($urandom);
            rd = 24'($urandom);
            rl = int'($urandom_range(1, 5));
            for (int i = 0; i < rl; i++) load_word(rs + 24'(4 * i), $urandom);
            run_copy(rs, rd, rl, 1'b0, 0);
            compare_mem($sformatf("rand%0d_mem", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
